// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the {row,col} to hex key map and the active-low column drive patterns.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Index is {row[1:0], col[1:0]}; entry 0 is r0/c0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [3:0][3:0] COL_DRIVE = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // Lowest-index row that reads low; callers only use it when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic width-N two-flop synchronizer; resets to all-ones so idle
// pulled-up inputs read inactive while the chain fills.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner: walks one active-low column at a time, debounces a
// single press and release, and emits a hex code with a one-cycle valid pulse.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

  logic [3:0]    row_s;

  state_e        state_q,     state_d;
  logic [1:0]    col_idx_q,   col_idx_d;
  logic [1:0]    row_idx_q,   row_idx_d;
  logic [SW-1:0] scan_cnt_q,  scan_cnt_d;
  logic [DW-1:0] deb_cnt_q,   deb_cnt_d;
  logic [3:0]    col_n_q,     col_n_d;
  logic [3:0]    key_code_q,  key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q,  key_down_d;
  logic          row_hit;

  sync2 #(.W(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_n),
    .q_o (row_s)
  );

  // Only the latched row matters once a key has been found.
  assign row_hit = ~row_s[row_idx_q];

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (~&row_s) begin
            row_idx_d = lowest_low_row(row_s);
            deb_cnt_d = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!row_hit) begin
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
          state_d    = ST_SCAN;
        end else if (deb_cnt_q == DEB_LAST) begin
          key_code_d  = KEY_MAP[{row_idx_q, col_idx_q}];
          key_valid_d = 1'b1;
          key_down_d  = 1'b1;
          state_d     = ST_HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end

      ST_HELD: begin
        if (!row_hit) begin
          deb_cnt_d = '0;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // A low reading here is contact bounce: restart the quiet window.
        if (row_hit) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          key_down_d = 1'b0;
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
          state_d    = ST_SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase

    col_n_d = COL_DRIVE[col_idx_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      col_n_q     <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      col_n_q     <= col_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder with a behavioural keypad matrix, directed
// timing scenarios and a randomized press/bounce/release phase.
`timescale 1ns/1ps
module tb_keypad_scan_encoder;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = '0;   // bit r*4+c set = key at row r, column c pressed

  int n_checks  = 0;
  int n_fail    = 0;
  int valid_cnt = 0;
  int v0;
  int rr, cc, nb;
  logic [3:0] exp_q[$];

  keypad_scan_encoder #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  function automatic logic [15:0] kbit(input int r, input int c);
    return 16'(1) << (r*4 + c);
  endfunction

  // Reference key legend, read row by row from the keypad face.
  function automatic logic [3:0] key_code_of(input int r, input int c);
    string labels;
    int    ch;
    labels = "123A456B789CE0FD";
    ch = int'(labels[r*4+c]);
    if (ch >= 48 && ch <= 57) return 4'(ch - 48);
    return 4'(ch - 65 + 10);
  endfunction

  function automatic logic [3:0] col_pattern(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: step(n) lands n cycles later, 1 ns after the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // After this returns, the current point is cycle 0 of the released design.
  task automatic do_reset(input logic [15:0] k);
    rst  = 1'b1;
    keys = k;
    step(3);
    rst  = 1'b0;
  endtask

  // Scoreboard: every valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    check("col_onehot", 32'($countones(~col_n)), 32'd1);
    if (key_valid === 1'b1) begin
      valid_cnt++;
      check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("valid_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
        check("down_at_valid", {31'd0, key_down}, 32'd1);
      end
    end
  end

  initial begin
    // Reset state
    step(1);
    check("rst_col", col_n, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);

    // Idle scan: each column low for SCAN_DIV cycles, wrapping.
    do_reset('0);
    for (int k = 0; k < 17; k++) begin
      check("idle_col", col_n, col_pattern((k / SCAN_DIV) % 4));
      check("idle_valid", key_valid, 1'b0);
      check("idle_down", key_down, 1'b0);
      step(1);
    end

    // Clean "5": column 1 sampled in cycle 7, valid in 7+1+8 = 16.
    exp_q.push_back(key_code_of(1, 1));
    v0 = valid_cnt;
    do_reset(kbit(1, 1));
    step(15);
    check("k5_pre", key_valid, 1'b0);
    step(1);
    check("k5_valid", key_valid, 1'b1);
    check("k5_code", key_code, 4'h5);
    check("k5_down", key_down, 1'b1);
    step(1);
    check("k5_pulse_end", key_valid, 1'b0);
    step(8);
    keys = '0;                        // released in cycle 25
    step(10);                         // 25 + 2 sync + 1 + 8 = 36
    check("k5_down_hold", key_down, 1'b1);
    check("k5_col_hold", col_n, 4'b1101);
    step(1);
    check("k5_down_fall", key_down, 1'b0);
    check("k5_col_next", col_n, 4'b1011);
    check("k5_count", valid_cnt - v0, 1);

    // "#" with bounce in the first debounce cycles.
    exp_q.push_back(key_code_of(3, 2));
    v0 = valid_cnt;
    do_reset(kbit(3, 2));
    step(13);
    keys = '0;
    step(1);
    keys = kbit(3, 2);
    step(1);
    keys = '0;
    step(1);
    keys = kbit(3, 2);
    step(4);
    check("hash_no_early", valid_cnt - v0, 0);
    step(60);
    check("hash_count", valid_cnt - v0, 1);
    check("hash_code", key_code, 4'hF);
    check("hash_down", key_down, 1'b1);
    keys = '0;
    step(20);
    check("hash_released", key_down, 1'b0);

    // "A" with release bounce: last low reading at raw cycle 38,
    // quiet window runs synced cycles 41..48, key_down falls in 49.
    exp_q.push_back(key_code_of(0, 3));
    v0 = valid_cnt;
    do_reset(kbit(0, 3));
    step(24);
    check("a_valid", key_valid, 1'b1);
    check("a_code", key_code, 4'hA);
    step(6);
    keys = '0;
    step(4);
    keys = kbit(0, 3);
    step(1);
    keys = '0;
    step(3);
    keys = kbit(0, 3);
    step(1);
    keys = '0;
    step(9);
    check("a_down_hold", key_down, 1'b1);
    check("a_col_hold", col_n, 4'b0111);
    step(1);
    check("a_down_fall", key_down, 1'b0);
    check("a_col_wrap", col_n, 4'b1110);
    check("a_count", valid_cnt - v0, 1);

    // "1" and "7" together, then "9" while "1" held.
    exp_q.push_back(key_code_of(0, 0));
    v0 = valid_cnt;
    do_reset(kbit(0, 0) | kbit(2, 0));
    step(12);
    check("k1_valid", key_valid, 1'b1);
    check("k1_code", key_code, 4'h1);
    step(8);
    keys = keys | kbit(2, 2);
    step(20);
    check("k9_ignored", valid_cnt - v0, 1);
    check("k1_code_hold", key_code, 4'h1);
    check("k1_down_hold", key_down, 1'b1);
    exp_q.push_back(key_code_of(2, 2));
    keys = kbit(2, 2);                // "1"/"7" released in cycle 40
    step(11);
    check("k1_down_fall", key_down, 1'b0);
    check("k1_col_next", col_n, 4'b1101);
    step(16);                         // column 2 sampled in 58, valid in 67
    check("k9_valid", key_valid, 1'b1);
    check("k9_code", key_code, 4'h9);
    check("k9_count", valid_cnt - v0, 2);
    keys = '0;
    step(20);

    // Reset while "D" is debouncing (sample 15, valid would be 24).
    v0 = valid_cnt;
    do_reset(kbit(3, 3));
    step(19);
    check("d_col_debounce", col_n, 4'b0111);
    rst = 1'b1;
    #1;
    check("d_rst_col", col_n, 4'b1110);
    check("d_rst_code", key_code, 4'h0);
    check("d_rst_down", key_down, 1'b0);
    check("d_rst_valid", key_valid, 1'b0);
    step(2);
    keys = '0;
    rst  = 1'b0;
    step(4);
    check("d_rescan", col_n, 4'b1101);
    step(30);
    check("d_no_valid", valid_cnt - v0, 0);
    check("d_down", key_down, 1'b0);

    // Randomized single presses with short press bounce.
    for (int it = 0; it < 8; it++) begin
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      v0 = valid_cnt;
      exp_q.push_back(key_code_of(rr, cc));
      step($urandom_range(0, 7));
      for (int b = 0; b < nb; b++) begin
        keys = kbit(rr, cc);
        step($urandom_range(1, 2));
        keys = '0;
        step(1);
      end
      keys = kbit(rr, cc);
      step(60);
      check("rand_count", valid_cnt - v0, 1);
      check("rand_code", key_code, key_code_of(rr, cc));
      check("rand_down", key_down, 1'b1);
      keys = '0;
      step(20);
      check("rand_release", key_down, 1'b0);
      check("rand_count_after", valid_cnt - v0, 1);
    end

    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
